accumulator_bank: RTL

ACCUMULATOR_BANK -- requirements
Module: accumulator_bank

---
 rtl/accumulator_bank.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/accumulator_bank.sv
// ---------------------------------------------------------------------------
// accumulator_bank
//
// Bank of CHANNELS independent WIDTH-bit accumulators. Three operations can
// target the bank in any cycle:
//   SetBase  - load a channel with an absolute value
//   Add      - fixed-latency add: a+b is issued now and accumulated into the
//              target channel LATENCY cycles later (no backpressure)
//   Drain    - read-and-clear a channel through a pop/ready handshake
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   SetBase_valid_in         load request
//   SetBase_channel_in       channel to load
//   SetBase_base_in          value to load
//   Add_valid_in             add issue
//   Add_channel_in           channel to accumulate into
//   Add_a_in, Add_b_in       add operands
//   Add_result_out           accumulator value produced by a committing add,
//                            0 in cycles without a commit
//   Drain_empty_in           drain request source is empty
//   Drain_channel_in         channel to read and clear
//   Drain_rden_out           pop the request source (same cycle as fire)
//   Drain_rdy_in             consumer ready
//   Drain_valid_out          drained value valid
//   Drain_result_out         drained value, 0 when not firing
//
// SATURATE = 0 wraps all additions modulo 2^WIDTH; SATURATE = 1 clamps them
// to all-ones.
// ---------------------------------------------------------------------------
module accumulator_bank #(
    parameter int  WIDTH    = 32,
    parameter int  CHANNELS = 4,
    parameter int  LATENCY  = 3,
    parameter int  SATURATE = 0,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SetBase_valid_in,
    input  logic [CW-1:0]    SetBase_channel_in,
    input  logic [WIDTH-1:0] SetBase_base_in,
    input  logic             Add_valid_in,
    input  logic [CW-1:0]    Add_channel_in,
    input  logic [WIDTH-1:0] Add_a_in,
    input  logic [WIDTH-1:0] Add_b_in,
    output logic [WIDTH-1:0] Add_result_out,
    input  logic             Drain_empty_in,
    input  logic [CW-1:0]    Drain_channel_in,
    output logic             Drain_rden_out,
    input  logic             Drain_rdy_in,
    output logic             Drain_valid_out,
    output logic [WIDTH-1:0] Drain_result_out
);

    // Shared adder used both for the operand sum and for accumulation, so the
    // wrap/clamp behaviour is identical on both.
    function automatic logic [WIDTH-1:0] add_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH:0] full;
        full = {1'b0, x} + {1'b0, y};
        if ((SATURATE != 0) && full[WIDTH]) begin
            return '1;
        end
        return full[WIDTH-1:0];
    endfunction

    logic [LATENCY-1:0] pipe_valid;
    logic [CW-1:0]      pipe_ch  [LATENCY];
    logic [WIDTH-1:0]   pipe_sum [LATENCY];

    logic [WIDTH-1:0]   acc      [CHANNELS];
    logic [WIDTH-1:0]   acc_next [CHANNELS];

    logic               commit_hit;
    logic [CW-1:0]      commit_ch;
    logic [WIDTH-1:0]   commit_value;
    logic               drain_fire;
    logic               drain_in_range;
    logic [WIDTH-1:0]   drain_value;

    // Add pipeline: the operand sum is formed at issue and carried with its
    // channel; the last stage is the commit point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_ch[i]  <= '0;
                pipe_sum[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= Add_valid_in;
            pipe_ch[0]    <= Add_channel_in;
            pipe_sum[0]   <= add_op(Add_a_in, Add_b_in);
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_ch[i]    <= pipe_ch[i-1];
                pipe_sum[i]   <= pipe_sum[i-1];
            end
        end
    end

    // Commit and drain lookups. Channel matching is done by comparison
    // rather than indexing so that out-of-range channels simply find nothing:
    // the commit is dropped and a drain returns 0.
    always_comb begin
        commit_ch      = pipe_ch[LATENCY-1];
        commit_hit     = 1'b0;
        commit_value   = '0;
        drain_in_range = 1'b0;
        drain_value    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (commit_ch == CW'(i)) begin
                commit_hit   = pipe_valid[LATENCY-1] & ~rst;
                commit_value = add_op(acc[i], pipe_sum[LATENCY-1]);
            end
            if (Drain_channel_in == CW'(i)) begin
                drain_in_range = 1'b1;
                drain_value    = acc[i];
            end
        end
        // A drain sees an add committing to the same channel this cycle.
        if (commit_hit && (commit_ch == Drain_channel_in)) begin
            drain_value = commit_value;
        end
    end

    assign drain_fire       = ~rst & ~Drain_empty_in & Drain_rdy_in;
    assign Drain_rden_out   = drain_fire;
    assign Drain_valid_out  = drain_fire;
    assign Drain_result_out = (drain_fire && drain_in_range) ? drain_value : '0;

    // A same-cycle SetBase to the committing channel overrides the add, and
    // the reported result follows the value that will actually be stored.
    always_comb begin
        Add_result_out = '0;
        if (commit_hit) begin
            if (SetBase_valid_in && (SetBase_channel_in == commit_ch)) begin
                Add_result_out = SetBase_base_in;
            end else begin
                Add_result_out = commit_value;
            end
        end
    end

    // Next value per channel, highest priority first: SetBase, drain clear,
    // add commit, hold.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            acc_next[i] = acc[i];
            if (SetBase_valid_in && (SetBase_channel_in == CW'(i))) begin
                acc_next[i] = SetBase_base_in;
            end else if (drain_fire && (Drain_channel_in == CW'(i))) begin
                acc_next[i] = '0;
            end else if (commit_hit && (commit_ch == CW'(i))) begin
                acc_next[i] = commit_value;
            end
        end
    end

    // Accumulator storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= acc_next[i];
            end
        end
    end

endmodule
